// File: rtl/diff_patch_unit_pkg.sv
// rtl/diff_patch_unit_pkg.sv - shared widths and state encodings for the diff patch engine
package diff_patch_unit_pkg;

   localparam int DP_WIDTH = 32;
   localparam int DP_IDX_W = $clog2(DP_WIDTH);

   // Encodings match the DIFF datapath so both engines can be traced side by side.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } dp_state_t;

endpackage

// File: rtl/diff_patch_unit_if.sv
// rtl/diff_patch_unit_if.sv - base, index and result handshake bundle for the patch engine
interface diff_patch_unit_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
);

   logic             base_valid;
   logic             base_ready;
   logic [WIDTH-1:0] base_data;
   logic             base_last;

   logic             idx_valid;
   logic             idx_ready;
   logic [IDX_W-1:0] idx_data;
   logic             idx_last;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [IDX_W:0]   res_count;
   logic             res_err;

   modport master (
      output base_valid, base_data, base_last,
      output idx_valid, idx_data, idx_last,
      output res_ready,
      input  base_ready, idx_ready,
      input  res_valid, res_data, res_count, res_err
   );

   modport slave (
      input  base_valid, base_data, base_last,
      input  idx_valid, idx_data, idx_last,
      input  res_ready,
      output base_ready, idx_ready,
      output res_valid, res_data, res_count, res_err
   );

endinterface

// File: rtl/diff_patch_unit_index_to_onehot.sv
// rtl/diff_patch_unit_index_to_onehot.sv - bit index to one-hot flip mask with range flag
module diff_patch_unit_index_to_onehot #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] onehot,
   output logic             in_range
);

   logic [31:0] idx_ext;

   // Widened so the compare stays meaningful when WIDTH is not a power of two.
   assign idx_ext  = 32'(idx);
   assign in_range = (idx_ext < 32'(WIDTH));
   assign onehot   = in_range ? ({{(WIDTH-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/diff_patch_unit.sv
// rtl/diff_patch_unit.sv - rebuilds a word from a base plus a stream of bit-flip indices
// Optional: DIFF_PATCH_ORDER_CHECK_EN flags indices that are not strictly increasing.
module diff_patch_unit
   import diff_patch_unit_pkg::*;
#(
   parameter int WIDTH = DP_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   diff_patch_unit_if.slave bus
);

   dp_state_t        state;
   dp_state_t        state_nxt;

   logic [WIDTH-1:0] acc;
   logic [IDX_W:0]   count;
   logic             err;

   logic [WIDTH-1:0] res_data_q;
   logic [IDX_W:0]   res_count_q;
   logic             res_err_q;

   logic             base_ready;
   logic             idx_ready;
   logic             res_valid;

   logic             base_hs;
   logic             idx_hs;
   logic             res_hs;

   logic [WIDTH-1:0] flip_mask;
   logic             idx_in_range;
   logic             order_err;

   logic [WIDTH-1:0] acc_upd;
   logic [IDX_W:0]   count_upd;
   logic             err_upd;

   // Handshakes are qualified by state directly so readies never depend on valids.
   assign base_hs = (state == ST_IDLE)  && bus.base_valid;
   assign idx_hs  = (state == ST_ACCUM) && bus.idx_valid;
   assign res_hs  = (state == ST_HOLD)  && bus.res_ready;

   diff_patch_unit_index_to_onehot #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_onehot (
      .idx      (bus.idx_data),
      .onehot   (flip_mask),
      .in_range (idx_in_range)
   );

`ifdef DIFF_PATCH_ORDER_CHECK_EN
   logic [IDX_W-1:0] prev_idx;
   logic             has_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_idx <= '0;
         has_prev <= 1'b0;
      end else if (base_hs) begin
         prev_idx <= '0;
         has_prev <= 1'b0;
      end else if (idx_hs) begin
         prev_idx <= bus.idx_data;
         has_prev <= 1'b1;
      end
   end

   assign order_err = has_prev && (bus.idx_data <= prev_idx);
`else
   assign order_err = 1'b0;
`endif

   assign acc_upd   = acc ^ flip_mask;
   assign count_upd = (count == {(IDX_W+1){1'b1}}) ? count : count + 1'b1;
   assign err_upd   = err | ~idx_in_range | order_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      base_ready = 1'b0;
      idx_ready  = 1'b0;
      res_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            base_ready = 1'b1;
            if (base_hs) begin
               state_nxt = bus.base_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            idx_ready = 1'b1;
            if (idx_hs && bus.idx_last) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            res_valid = 1'b1;
            if (res_hs) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Result registers load only on entry to HOLD, so they freeze across stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc         <= '0;
         count       <= '0;
         err         <= 1'b0;
         res_data_q  <= '0;
         res_count_q <= '0;
         res_err_q   <= 1'b0;
      end else if (base_hs) begin
         acc   <= bus.base_data;
         count <= '0;
         err   <= 1'b0;
         if (bus.base_last) begin
            res_data_q  <= bus.base_data;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
         end
      end else if (idx_hs) begin
         acc   <= acc_upd;
         count <= count_upd;
         err   <= err_upd;
         if (bus.idx_last) begin
            res_data_q  <= acc_upd;
            res_count_q <= count_upd;
            res_err_q   <= err_upd;
         end
      end
   end

   assign bus.base_ready = base_ready;
   assign bus.idx_ready  = idx_ready;
   assign bus.res_valid  = res_valid;
   assign bus.res_data   = res_data_q;
   assign bus.res_count  = res_count_q;
   assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_diff_patch_unit.sv
// tb/tb_diff_patch_unit.sv - self-checking bench for diff_patch_unit
module tb_diff_patch_unit;

`ifdef DIFF_PATCH_ORDER_CHECK_EN
   localparam bit ORD = 1'b1;
`else
   localparam bit ORD = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   logic [4:0] stim_q[$];

   diff_patch_unit_if #(.WIDTH(32), .IDX_W(5)) bus ();

   diff_patch_unit #(.WIDTH(32), .IDX_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] base;
      logic        blast;
      int          n;
      logic [3:0][4:0] idxs;
      logic [31:0] exp_data;
      int          exp_count;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   function automatic void ref_model(input logic [31:0] base, input logic [4:0] q[$],
                                     output logic [31:0] d, output int c, output logic e);
      d = base;
      c = 0;
      e = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         d = d ^ (32'h1 << q[i]);
         c = (c < 63) ? c + 1 : 63;
         if (ORD && i > 0 && q[i] <= q[i-1]) e = 1'b1;
      end
   endfunction

   // Called at a negedge; returns at the negedge where the result should be visible.
   task automatic send_patch(input logic [31:0] base, input logic blast);
      int t;
      bus.base_valid = 1'b1;
      bus.base_data  = base;
      bus.base_last  = blast;
      t = 0;
      while (!bus.base_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("base_accept", 64'(bus.base_ready), 64'd1);
      @(negedge clk);
      bus.base_valid = 1'b0;
      bus.base_last  = 1'b0;
      if (blast) begin
         chk("no_idx_ready", 64'(bus.idx_ready), 64'd0);
      end else begin
         for (int i = 0; i < stim_q.size(); i++) begin
            bus.idx_valid = 1'b1;
            bus.idx_data  = stim_q[i];
            bus.idx_last  = (i == stim_q.size() - 1);
            t = 0;
            while (!bus.idx_ready && t < 20) begin
               @(negedge clk);
               t++;
            end
            if (t >= 20) chk("idx_accept_timeout", 64'(bus.idx_ready), 64'd1);
            @(negedge clk);
         end
         bus.idx_valid = 1'b0;
         bus.idx_last  = 1'b0;
      end
      chk("latency_res_valid", 64'(bus.res_valid), 64'd1);
   endtask

   task automatic check_result(input string name, input logic [31:0] d, input int c, input logic e);
      chk({name, "_data"},  64'(bus.res_data),  64'(d));
      chk({name, "_count"}, 64'(bus.res_count), 64'(c));
      chk({name, "_err"},   64'(bus.res_err),   64'(e));
   endtask

   task automatic take_result();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_valid_drop", 64'(bus.res_valid), 64'd0);
      chk("base_ready_after", 64'(bus.base_ready), 64'd1);
   endtask

   task automatic run_ref(input string name, input logic [31:0] base);
      logic [31:0] d;
      int          c;
      logic        e;
      ref_model(base, stim_q, d, c, e);
      send_patch(base, 1'b0);
      check_result(name, d, c, e);
      take_result();
   endtask

   initial begin
      logic [31:0] a, b, snap;
      total  = 0;
      passed = 0;
      rst_n  = 1'b0;
      bus.base_valid = 1'b0;
      bus.base_data  = '0;
      bus.base_last  = 1'b0;
      bus.idx_valid  = 1'b0;
      bus.idx_data   = '0;
      bus.idx_last   = 1'b0;
      bus.res_ready  = 1'b0;

      vecs[0] = '{"t1", 32'h0000_00F0, 1'b0, 2, {5'd0, 5'd0, 5'd3, 5'd0}, 32'h0000_00F9, 2, 1'b0};
      vecs[1] = '{"t2", 32'hDEAD_BEEF, 1'b1, 0, {5'd0, 5'd0, 5'd0, 5'd0}, 32'hDEAD_BEEF, 0, 1'b0};
      vecs[2] = '{"t3", 32'h0000_0000, 1'b0, 2, {5'd0, 5'd0, 5'd31, 5'd31}, 32'h0000_0000, 2, ORD};
      vecs[3] = '{"t4", 32'hFFFF_FFFF, 1'b0, 4, {5'd31, 5'd2, 5'd1, 5'd0}, 32'h7FFF_FFF8, 4, 1'b0};
      vecs[4] = '{"t5", 32'h1234_5678, 1'b0, 1, {5'd0, 5'd0, 5'd0, 5'd4}, 32'h1234_5668, 1, 1'b0};
      vecs[5] = '{"t6", 32'h0000_0000, 1'b0, 2, {5'd0, 5'd0, 5'd2, 5'd5}, 32'h0000_0024, 2, ORD};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_base_ready", 64'(bus.base_ready), 64'd1);
      chk("rst_idx_ready",  64'(bus.idx_ready),  64'd0);
      chk("rst_res_valid",  64'(bus.res_valid),  64'd0);
      check_result("rst", 32'h0, 0, 1'b0);

      for (int v = 0; v < 6; v++) begin
         stim_q = {};
         for (int k = 0; k < vecs[v].n; k++) stim_q.push_back(vecs[v].idxs[k]);
         send_patch(vecs[v].base, vecs[v].blast);
         check_result(vecs[v].name, vecs[v].exp_data, vecs[v].exp_count, vecs[v].exp_err);
         take_result();
      end

      // Consumer stall: result must stay frozen and no new base accepted.
      stim_q = {5'd8};
      send_patch(32'hA5A5_0000, 1'b0);
      snap = 32'hA5A5_0100;
      for (int s = 0; s < 5; s++) begin
         chk("stall_valid", 64'(bus.res_valid), 64'd1);
         chk("stall_data", 64'(bus.res_data), 64'(snap));
         chk("stall_base_ready", 64'(bus.base_ready), 64'd0);
         @(negedge clk);
      end
      take_result();

      // Reset after two of four beats discards the patch.
      bus.base_valid = 1'b1;
      bus.base_data  = 32'hFFFF_0000;
      @(negedge clk);
      bus.base_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.idx_valid = 1'b1;
         bus.idx_data  = 5'(i);
         bus.idx_last  = 1'b0;
         @(negedge clk);
      end
      bus.idx_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("midrst_base_ready", 64'(bus.base_ready), 64'd1);
      chk("midrst_res_data", 64'(bus.res_data), 64'd0);
      stim_q = {5'd1, 5'd9};
      send_patch(32'h0000_0000, 1'b0);
      check_result("after_rst", 32'h0000_0202, 2, 1'b0);
      take_result();

      // Count saturation: 64 beats flip every bit twice.
      stim_q = {};
      for (int i = 0; i < 64; i++) stim_q.push_back(5'(i % 32));
      run_ref("sat", 32'hC0FF_EE00);

      // DIFF round trip with ascending differing-bit indices.
      for (int r = 0; r < 12; r++) begin
         a = $urandom;
         b = (r == 0) ? a : $urandom;
         stim_q = {};
         for (int i = 0; i < 32; i++) if (a[i] != b[i]) stim_q.push_back(5'(i));
         if (stim_q.size() == 0) begin
            send_patch(a, 1'b1);
            check_result("rt_equal", b, 0, 1'b0);
            take_result();
         end else begin
            send_patch(a, 1'b0);
            check_result("roundtrip", b, stim_q.size(), 1'b0);
            take_result();
         end
      end

      // Random unordered index streams, duplicates allowed.
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(1, 6);
         stim_q = {};
         for (int i = 0; i < n; i++) stim_q.push_back(5'($urandom_range(0, 31)));
         run_ref("rand", $urandom);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
